// File: rtl/mem_bus_interface.sv
// MAR/MDR register pair with a handshaked memory port: one read or write per
// request, bounded wait on mem_ack, one-cycle done/err completion pulses.
module mem_bus_interface #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              enableMAR,
    input  logic              enableMDR,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] BusMuxInMDR,
    output logic [DATA_W-1:0] MARout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;

        // Register loads are locked out in ACCESS so the memory sees stable address/data.
        if (state_q != ACCESS) begin
            if (enableMAR) mar_d = BusMuxOut;
            if (enableMDR) mdr_d = BusMuxOut;
        end

        case (state_q)
            IDLE: begin
                if (rd_req && wr_req) begin
                    state_d = ERR;
                end else if (rd_req || wr_req) begin
                    state_d = ACCESS;
                    we_d    = wr_req;
                    cnt_d   = 8'd0;
                end
            end
            ACCESS: begin
                // An ack on the last allowed cycle still completes the access.
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) mdr_d = mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        req_d  = (state_d == ACCESS);
        done_d = (state_d == DONE);
        err_d  = (state_d == ERR);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            mar_q   <= '0;
            mdr_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_req     = req_q;
    assign busy        = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = mar_q[ADDR_W-1:0];
    assign mem_wdata   = mdr_q;
    assign BusMuxInMDR = mdr_q;
    assign MARout      = mar_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: doc/mem_bus_interface.md
MEM_BUS_INTERFACE -- requirements
Module: mem_bus_interface

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of bus, MAR data and MDR data.
REQ-002 SHALL have parameter ADDR_W, default 9, number of MAR bits driven to memory (MAR[ADDR_W-1:0]).
REQ-003 SHALL have parameter TIMEOUT, default 15, range 1..255, maximum cycles waited for mem_ack.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, as follows.
REQ-005 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port clear  in  1  asynchronous active-low reset.
REQ-007 SHALL have port BusMuxOut  in  DATA_W  datapath bus, source for MAR and bus-sourced MDR loads.
REQ-008 SHALL have port enableMAR  in  1  load MAR from BusMuxOut.
REQ-009 SHALL have port enableMDR  in  1  load MDR from BusMuxOut.
REQ-010 SHALL have port rd_req  in  1  start memory read, one-cycle pulse.
REQ-011 SHALL have port wr_req  in  1  start memory write of MDR to address MAR, one-cycle pulse.
REQ-012 SHALL have port mem_rdata  in  DATA_W  read data from memory.
REQ-013 SHALL have port mem_ack  in  1  memory completion; valid only while mem_req is high.
REQ-014 SHALL have port mem_req  out  1  memory access request.
REQ-015 SHALL have port mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req is high.
REQ-016 SHALL have port mem_addr  out  ADDR_W  equals MAR[ADDR_W-1:0].
REQ-017 SHALL have port mem_wdata  out  DATA_W  equals MDR.
REQ-018 SHALL have port BusMuxInMDR  out  DATA_W  MDR contents, to bus mux.
REQ-019 SHALL have port MARout  out  DATA_W  MAR contents.
REQ-020 SHALL have port busy  out  1  high in ACCESS state.
REQ-021 SHALL have port done  out  1  one-cycle pulse on successful completion.
REQ-022 SHALL have port err  out  1  one-cycle pulse on timeout or rejected request.

Function
REQ-023 SHALL implement FSM states IDLE, ACCESS, DONE, ERR.
REQ-024 In IDLE, exactly one of rd_req or wr_req SHALL move the FSM to ACCESS on the next edge, latching mem_we (1 for wr_req) and clearing the wait counter.
REQ-025 In IDLE, rd_req and wr_req together SHALL be rejected: next state ERR, no memory access.
REQ-026 rd_req or wr_req outside IDLE SHALL be ignored with no other effect.
REQ-027 mem_req SHALL be 1 exactly while in ACCESS, registered output, no combinational path from any input.
REQ-028 In ACCESS, mem_ack=1 SHALL move the FSM to DONE; on a read, MDR SHALL load mem_rdata on that same edge.
REQ-029 In ACCESS with mem_ack=0, the wait counter SHALL increment; on the edge where the counter equals TIMEOUT-1, the FSM SHALL go to ERR, MDR unchanged.
REQ-030 mem_ack on the final timeout cycle SHALL take priority over the timeout (DONE).
REQ-031 DONE and ERR SHALL each last one cycle, return to IDLE, and assert done/err respectively; requests are not accepted in these states.
REQ-032 enableMAR and enableMDR SHALL be honoured only in IDLE, DONE and ERR; they SHALL be ignored in ACCESS so mem_addr/mem_wdata stay stable.
REQ-033 Within the accepting states, a read capture per REQ-028 SHALL take priority over enableMDR in the same cycle.
REQ-034 A write SHALL never modify MDR or MAR.
REQ-035 Minimum latency SHALL be request edge to DONE in 2 cycles (ack in first ACCESS cycle), with done high in cycle 3.

Reset
REQ-036 clear=0 SHALL asynchronously force the FSM to IDLE and set MAR=0, MDR=0, wait counter=0, mem_req=0, mem_we=0, busy=0, done=0, err=0.
REQ-037 Reset during ACCESS SHALL drop mem_req immediately, without waiting for a clock edge, and discard the access; mem_ack after reset SHALL be ignored.

Verification
REQ-038 Load MAR=0x95, rd_req; mem_ack after 3 waits with mem_rdata=0x1234ABCD -> BusMuxInMDR=0x1234ABCD, done pulse, busy high 4 cycles.
REQ-039 MAR=0x87, MDR=0x43, wr_req, ack in first cycle -> mem_we=1, mem_addr=0x87, mem_wdata=0x43 for 1 cycle, done at cycle 3, MDR still 0x43.
REQ-040 TIMEOUT=15, rd_req, no ack -> err pulse after 15 ACCESS cycles, MDR unchanged, next rd_req accepted.
REQ-041 rd_req and wr_req together -> err pulse next cycle, mem_req never asserted.
REQ-042 enableMAR with BusMuxOut=0xFF during ACCESS -> mem_addr unchanged; clear=0 mid-ACCESS -> mem_req=0 before the next edge, all outputs at reset values.
